// File: rtl/mem_display_scan.sv
// mem_display_scan
//   Shows one 16-bit half of a captured 32-bit memory word on a 4-digit
//   multiplexed 7-segment display. A debounced push button flips which
//   half is shown. The decimal point on digit 0 marks the upper half.
//   Leading zero digits can optionally be blanked.
//
// Ports
//   clk         system clock, rising edge
//   rst_n       synchronous active-low reset
//   data_in     word to display, captured when data_valid=1
//   data_valid  single-cycle capture strobe
//   page_btn    raw asynchronous button; each debounced press toggles page
//   blank_lz    1 = blank leading zero digits (digit 0 is always shown)
//   AN          digit enables, active-low, AN[0] = least significant digit
//   seg         segments, active-low, {dp,g,f,e,d,c,b,a}
module mem_display_scan #(
  parameter int REFRESH_DIV  = 50000,
  parameter int DEBOUNCE_CNT = 500000
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] data_in,
  input  logic        data_valid,
  input  logic        page_btn,
  input  logic        blank_lz,
  output logic [3:0]  AN,
  output logic [7:0]  seg
);

  localparam int RW = (REFRESH_DIV  > 2) ? $clog2(REFRESH_DIV)  : 1;
  localparam int DW = (DEBOUNCE_CNT > 2) ? $clog2(DEBOUNCE_CNT) : 1;

  logic [31:0]   disp_word;
  logic          page;
  logic [1:0]    btn_sync;
  logic          btn_db;
  logic [DW-1:0] db_cnt;
  logic [RW-1:0] ref_cnt;
  logic [1:0]    dig;

  function automatic logic [6:0] hex7(input logic [3:0] n);
    case (n)
      4'h0: hex7 = 7'h40;  4'h1: hex7 = 7'h79;
      4'h2: hex7 = 7'h24;  4'h3: hex7 = 7'h30;
      4'h4: hex7 = 7'h19;  4'h5: hex7 = 7'h12;
      4'h6: hex7 = 7'h02;  4'h7: hex7 = 7'h78;
      4'h8: hex7 = 7'h00;  4'h9: hex7 = 7'h10;
      4'hA: hex7 = 7'h08;  4'hB: hex7 = 7'h03;
      4'hC: hex7 = 7'h46;  4'hD: hex7 = 7'h21;
      4'hE: hex7 = 7'h06;  default: hex7 = 7'h0E;
    endcase
  endfunction

  // Debounce: the synchronized level must disagree with btn_db for
  // DEBOUNCE_CNT consecutive clocks; any agreement restarts the count.
  logic db_accept;
  assign db_accept = (btn_sync[1] != btn_db) && (db_cnt == DW'(DEBOUNCE_CNT - 1));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      disp_word <= '0;
      page      <= 1'b0;
      btn_sync  <= '0;
      btn_db    <= 1'b0;
      db_cnt    <= '0;
      ref_cnt   <= '0;
      dig       <= '0;
    end else begin
      if (data_valid) disp_word <= data_in;
      btn_sync <= {btn_sync[0], page_btn};
      if (btn_sync[1] == btn_db) begin
        db_cnt <= '0;
      end else if (db_accept) begin
        db_cnt <= '0;
        btn_db <= btn_sync[1];
        if (btn_sync[1]) page <= ~page;  // only the press edge flips page
      end else begin
        db_cnt <= db_cnt + 1'b1;
      end
      if (ref_cnt == RW'(REFRESH_DIV - 1)) begin
        ref_cnt <= '0;
        dig     <= dig + 2'd1;
      end else begin
        ref_cnt <= ref_cnt + 1'b1;
      end
    end
  end

  // Output decode from current state; registered so outputs trail the
  // scan index by exactly one clock.
  logic [15:0] half;
  logic [3:0]  nib;
  logic [3:0]  lead_zero;  // lead_zero[k]: nibbles k..3 are all zero
  logic        blank;

  always_comb begin
    half         = page ? disp_word[31:16] : disp_word[15:0];
    nib          = half[dig*4 +: 4];
    lead_zero    = '0;
    lead_zero[3] = (half[15:12] == 4'h0);
    lead_zero[2] = lead_zero[3] && (half[11:8] == 4'h0);
    lead_zero[1] = lead_zero[2] && (half[7:4]  == 4'h0);
    blank        = blank_lz && lead_zero[dig];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      AN  <= 4'hF;
      seg <= 8'hFF;
    end else if (blank) begin
      AN  <= 4'hF;
      seg <= 8'hFF;
    end else begin
      AN  <= ~(4'b0001 << dig);
      seg <= {~((dig == 2'd0) && page), hex7(nib)};
    end
  end

endmodule
